// File: rtl/axis_oversample_n_if.sv
// AXI-Stream style beat bus shared by the input and output sides of the
// oversampler.
//
// Handshake: a beat moves on a rising clock edge where tvalid and tready are
// both high. Once the sender raises tvalid, it holds tvalid, tdata and tlast
// steady until that edge. tready may change at any time and never depends on
// a future tvalid.
interface axis_oversample_n_if #(
  parameter int DATA_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_oversample_n.sv
// Stream oversampler: each accepted input beat is replayed F times on the
// output. F is the runtime factor, clamped to 1..MAX_FACTOR and latched with
// the beat. MODE 0 repeats the sample on every replica. MODE 1 sends the
// sample once and then F-1 all-zero beats (zero stuffing). tlast is placed
// only on the final replica of a beat that arrived with tlast set.
module axis_oversample_n #(
  parameter  int DATA_WIDTH = 1,
  parameter  int MAX_FACTOR = 8,
  parameter  int MODE       = 0,
  localparam int FW         = $clog2(MAX_FACTOR + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [FW-1:0]        i_ovs_factor,
  axis_oversample_n_if.slave   s_axis,
  axis_oversample_n_if.master  m_axis,
  output logic                 o_dbg_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [FW-1:0] MAX_F = FW'(MAX_FACTOR);

  state_t                state_q, state_d;
  logic [FW-1:0]         cnt_q, cnt_d;
  logic [FW-1:0]         fac_q, fac_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;

  logic [FW-1:0]         eff_factor;
  logic                  last_rep;
  logic                  accept;
  logic                  out_hs;

  // Clamp the requested factor into the legal 1..MAX_FACTOR range.
  always_comb begin
    eff_factor = i_ovs_factor;
    if (i_ovs_factor == '0) begin
      eff_factor = FW'(1);
    end else if (i_ovs_factor > MAX_F) begin
      eff_factor = MAX_F;
    end
  end

  // Output side and input ready. A new beat may enter while the last replica
  // is being taken, so the stream runs without a bubble. Reset forces
  // tready low even though the state already reads IDLE.
  always_comb begin
    last_rep      = (cnt_q == (fac_q - FW'(1)));
    m_axis.tvalid = (state_q == S_BUSY);
    m_axis.tlast  = (state_q == S_BUSY) && last_q && last_rep;
    if ((MODE == 1) && (cnt_q != '0)) begin
      m_axis.tdata = '0;
    end else begin
      m_axis.tdata = data_q;
    end
    s_axis.tready = i_rst_n &&
                    ((state_q == S_IDLE) || (last_rep && m_axis.tready));
    accept        = s_axis.tvalid && s_axis.tready;
    out_hs        = m_axis.tvalid && m_axis.tready;
    o_dbg_busy    = (state_q == S_BUSY);
  end

  // Next state: a new acceptance always wins because it can only happen in
  // IDLE or on the final-replica handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fac_d   = fac_q;
    data_d  = data_q;
    last_d  = last_q;
    if (accept) begin
      state_d = S_BUSY;
      cnt_d   = '0;
      fac_d   = eff_factor;
      data_d  = s_axis.tdata;
      last_d  = s_axis.tlast;
    end else if (out_hs) begin
      if (last_rep) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + FW'(1);
      end
    end
  end

  // State and holding registers; reset discards any beat in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fac_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fac_q   <= fac_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_axis_oversample_n.sv
// Bench for axis_oversample_n. Three instances share one input stream:
// dut_a (8-bit, MODE 0), dut_b (8-bit, MODE 1), dut_c (1-bit, MODE 0).
// All have MAX_FACTOR = 8, so the factor field is 4 bits wide.
module tb_axis_oversample_n;

  localparam int FW = 4;

  // ---------------- clock / reset ----------------
  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic [FW-1:0] factor = 4'd4;
  logic [7:0]    s_tdata = 8'h00;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b1;
  logic          dbg_a, dbg_b, dbg_c;

  always #5 i_clk = ~i_clk;

  axis_oversample_n_if #(.DATA_WIDTH(8)) sa ();
  axis_oversample_n_if #(.DATA_WIDTH(8)) ma ();
  axis_oversample_n_if #(.DATA_WIDTH(8)) sb ();
  axis_oversample_n_if #(.DATA_WIDTH(8)) mb ();
  axis_oversample_n_if #(.DATA_WIDTH(1)) sc ();
  axis_oversample_n_if #(.DATA_WIDTH(1)) mc ();

  assign sa.tdata = s_tdata;    assign sa.tvalid = s_tvalid; assign sa.tlast = s_tlast;
  assign sb.tdata = s_tdata;    assign sb.tvalid = s_tvalid; assign sb.tlast = s_tlast;
  assign sc.tdata = s_tdata[0]; assign sc.tvalid = s_tvalid; assign sc.tlast = s_tlast;
  assign ma.tready = m_tready;
  assign mb.tready = m_tready;
  assign mc.tready = m_tready;

  axis_oversample_n #(.DATA_WIDTH(8), .MAX_FACTOR(8), .MODE(0)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ovs_factor(factor),
    .s_axis(sa), .m_axis(ma), .o_dbg_busy(dbg_a));
  axis_oversample_n #(.DATA_WIDTH(8), .MAX_FACTOR(8), .MODE(1)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ovs_factor(factor),
    .s_axis(sb), .m_axis(mb), .o_dbg_busy(dbg_b));
  axis_oversample_n #(.DATA_WIDTH(1), .MAX_FACTOR(8), .MODE(0)) dut_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ovs_factor(factor),
    .s_axis(sc), .m_axis(mc), .o_dbg_busy(dbg_c));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic vld(input int sel);
    case (sel)
      0:       return ma.tvalid;
      1:       return mb.tvalid;
      default: return mc.tvalid;
    endcase
  endfunction

  function automatic logic [8:0] word(input int sel);
    case (sel)
      0:       return {ma.tlast, ma.tdata};
      1:       return {mb.tlast, mb.tdata};
      default: return {mc.tlast, 7'b0, mc.tdata};
    endcase
  endfunction

  // Expected replica table for directed checks: {tlast, tdata}.
  logic [8:0] exp_tab [32];

  task automatic fill(input int off, input int n, input logic [7:0] d,
                      input bit zero_stuff, input logic l);
    for (int i = 0; i < n; i++) begin
      exp_tab[off+i] = {(l && (i == n - 1)), ((zero_stuff && i != 0) ? 8'h00 : d)};
    end
  endtask

  // Waits for the first valid output of DUT 'sel', then requires n valid
  // beats on consecutive cycles matching exp_tab, then an idle cycle.
  task automatic watch(input int sel, input int n, input string tag);
    int waitc = 0;
    @(negedge i_clk);
    while (!vld(sel)) begin
      waitc++;
      if (waitc > 50) begin
        check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        return;
      end
      @(negedge i_clk);
    end
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_valid%0d", tag, i), {31'd0, vld(sel)}, 32'd1);
      check_eq($sformatf("%s_beat%0d", tag, i), {23'd0, word(sel)}, {23'd0, exp_tab[i]});
      @(negedge i_clk);
    end
    check_eq({tag, "_idle"}, {31'd0, vld(sel)}, 32'd0);
  endtask

  // ---------------- scoreboard (dut_a) ----------------
  logic [8:0] exp_q[$];
  bit         sb_en = 1'b0;
  int         sb_factor = 5;
  int         out_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [9:0] prev_word = '0;

  always @(negedge i_clk) begin
    logic [8:0] e;
    if (sb_en) begin
      if (prev_stall) check_eq("stall_stable", {22'd0, ma.tvalid, ma.tlast, ma.tdata}, {22'd0, prev_word});
      if (ma.tvalid && m_tready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("sb_nonempty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_beat", {23'd0, ma.tlast, ma.tdata}, {23'd0, e});
        end
      end
      prev_stall = ma.tvalid && !m_tready;
      prev_word  = {ma.tvalid, ma.tlast, ma.tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input bit push);
    logic rdy;
    int   n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    forever begin
      @(negedge i_clk);
      rdy = sa.tready;
      @(posedge i_clk);
      #1;
      if (rdy) begin
        if (push) begin
          for (int k = 0; k < sb_factor; k++) exp_q.push_back({(l && k == sb_factor - 1), d});
        end
        break;
      end
      n++;
      if (n > 200) begin
        check_eq("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  bit rnd_en = 1'b0;
  always @(posedge i_clk) begin
    if (rnd_en) begin
      #1;
      m_tready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- sequence ----------------
  initial begin
    int gap;
    #1 i_rst_n = 1'b0;
    #2;
    check_eq("rst_m_tvalid", {31'd0, ma.tvalid}, 32'd0);
    check_eq("rst_m_tlast",  {31'd0, ma.tlast},  32'd0);
    check_eq("rst_m_tdata",  {24'd0, ma.tdata},  32'd0);
    check_eq("rst_s_tready", {31'd0, sa.tready}, 32'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_eq("idle_s_tready", {31'd0, sa.tready}, 32'd1);
    check_eq("idle_busy", {31'd0, dbg_a}, 32'd0);

    // 1-bit, factor 4: 1,0,1 -> 1111 0000 1111, tlast on 12th cycle
    factor = 4'd4;
    fill(0, 4, 8'h01, 1'b0, 1'b0);
    fill(4, 4, 8'h00, 1'b0, 1'b0);
    fill(8, 4, 8'h01, 1'b0, 1'b1);
    fork
      begin send(8'h01, 1'b0, 1'b0); send(8'h00, 1'b0, 1'b0); send(8'h01, 1'b1, 1'b0); end
      watch(2, 12, "bit_f4");
    join

    // MODE 1, factor 3: A5,3C -> A5,0,0,3C,0,0
    @(posedge i_clk); #1;
    factor = 4'd3;
    fill(0, 3, 8'hA5, 1'b1, 1'b0);
    fill(3, 3, 8'h3C, 1'b1, 1'b1);
    fork
      begin send(8'hA5, 1'b0, 1'b0); send(8'h3C, 1'b1, 1'b0); end
      watch(1, 6, "zstuff_f3");
    join

    // factor 0 -> 1 replica; factor 13 -> clamped to 8
    @(posedge i_clk); #1;
    factor = 4'd0;
    fill(0, 1, 8'h42, 1'b0, 1'b1);
    fork
      send(8'h42, 1'b1, 1'b0);
      watch(0, 1, "f0");
    join
    @(posedge i_clk); #1;
    factor = 4'd13;
    fill(0, 8, 8'h99, 1'b0, 1'b1);
    fork
      send(8'h99, 1'b1, 1'b0);
      watch(0, 8, "f13");
    join

    // factor 2 -> 6 changed while the first beat is in flight
    @(posedge i_clk); #1;
    factor = 4'd2;
    fill(0, 2, 8'h11, 1'b0, 1'b0);
    fill(2, 6, 8'h22, 1'b0, 1'b1);
    fork
      begin send(8'h11, 1'b0, 1'b0); factor = 4'd6; send(8'h22, 1'b1, 1'b0); end
      watch(0, 8, "fchg");
    join

    // reset after 2 of 4 replicas
    @(posedge i_clk); #1;
    factor = 4'd4;
    send(8'h5A, 1'b0, 1'b0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", {31'd0, ma.tvalid}, 32'd0);
    check_eq("mid_rst_tdata",  {24'd0, ma.tdata},  32'd0);
    check_eq("mid_rst_tready", {31'd0, sa.tready}, 32'd0);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_eq("post_rst_no_replica", {31'd0, ma.tvalid}, 32'd0);
    @(posedge i_clk); #1;
    fill(0, 4, 8'h77, 1'b0, 1'b1);
    fork
      send(8'h77, 1'b1, 1'b0);
      watch(0, 4, "post_rst_f4");
    join

    // random tready, factor 5, 200 beats against the scoreboard
    @(posedge i_clk); #1;
    factor    = 4'd5;
    sb_factor = 5;
    out_cnt   = 0;
    sb_en     = 1'b1;
    rnd_en    = 1'b1;
    for (int b = 0; b < 200; b++) begin
      gap = $urandom_range(0, 1);
      repeat (gap) begin @(posedge i_clk); #1; end
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b1);
    end
    rnd_en = 1'b0;
    @(posedge i_clk); #1;
    m_tready = 1'b1;
    for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(posedge i_clk);
    @(negedge i_clk);
    sb_en = 1'b0;
    check_eq("sb_out_count", out_cnt, 32'd1000);
    check_eq("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
